// File: rtl/mix_columns_pkg.sv
// Shared AES package (aes_pkg): GF(2^8) helpers, reduction constant, byte/state types.
// Latency: none, the functions are pure combinational logic.
// Backpressure: not applicable; also reused by SubBytes and the key schedule.
package aes_pkg;

  // Low byte of the AES field modulus x^8+x^4+x^3+x+1 (0x11b).
  localparam logic [7:0] GF_RED = 8'h1b;

  typedef logic [7:0] byte_t;
  // Packed column: element 0 is the top row, held in the most significant byte.
  typedef byte_t [0:3] column_t;
  // Column-major state: element 4c+r is row r of column c; element 0 is the MSB.
  typedef byte_t [0:15] state_t;

  // Multiply by x (02) in GF(2^8).
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add. With a constant operand,
  // synthesis folds this down to a fixed xor network.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_columns_if.sv
// Request/result bus for the MixColumns stage: input state with its valid, and registered result with its valid.
// Latency: none, wiring only.
// Backpressure: none; the stage accepts one state per cycle without stalling.
interface mix_columns_if;
  logic           in_valid;
  logic [0:127]   ShiftRows_Matrix;
  logic           out_valid;
  logic [0:127]   MixColumns_Matrix;

  modport master (
    output in_valid,
    output ShiftRows_Matrix,
    input  out_valid,
    input  MixColumns_Matrix
  );

  modport slave (
    input  in_valid,
    input  ShiftRows_Matrix,
    output out_valid,
    output MixColumns_Matrix
  );
endinterface

// File: rtl/mix_columns_mix_single_column.sv
// One 4-byte column times the fixed (Inv)MixColumns matrix over GF(2^8).
// Latency: purely combinational.
// Backpressure: none; the output follows the input directly.
module mix_single_column #(
  parameter bit INVERSE = 1'b0
) (
  input  aes_pkg::column_t colIn,
  output aes_pkg::column_t colOut
);
  import aes_pkg::*;

  byte_t mul2 [4];
  byte_t mul4 [4];
  byte_t mul8 [4];
  byte_t mul3 [4];
  byte_t mul9 [4];
  byte_t mulB [4];
  byte_t mulD [4];
  byte_t mulE [4];

  // Build every needed multiple of each byte from one xtime chain.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mul2[i] = xtime(colIn[i]);
      mul4[i] = xtime(mul2[i]);
      mul8[i] = xtime(mul4[i]);
      mul3[i] = mul2[i] ^ colIn[i];
      mul9[i] = mul8[i] ^ colIn[i];
      mulB[i] = mul8[i] ^ mul2[i] ^ colIn[i];
      mulD[i] = mul8[i] ^ mul4[i] ^ colIn[i];
      mulE[i] = mul8[i] ^ mul4[i] ^ mul2[i];
    end
  end

  // Apply the rotated matrix rows: 02 03 01 01 going forward, 0e 0b 0d 09 going inverse.
  always_comb begin
    colOut = '0;
    if (INVERSE) begin
      colOut[0] = mulE[0] ^ mulB[1] ^ mulD[2] ^ mul9[3];
      colOut[1] = mul9[0] ^ mulE[1] ^ mulB[2] ^ mulD[3];
      colOut[2] = mulD[0] ^ mul9[1] ^ mulE[2] ^ mulB[3];
      colOut[3] = mulB[0] ^ mulD[1] ^ mul9[2] ^ mulE[3];
    end else begin
      colOut[0] = mul2[0] ^ mul3[1] ^ colIn[2] ^ colIn[3];
      colOut[1] = colIn[0] ^ mul2[1] ^ mul3[2] ^ colIn[3];
      colOut[2] = colIn[0] ^ colIn[1] ^ mul2[2] ^ mul3[3];
      colOut[3] = mul3[0] ^ colIn[1] ^ colIn[2] ^ mul2[3];
    end
  end

endmodule

// File: rtl/mix_columns.sv
// AES (Inv)MixColumns round stage: four independent column mixers feeding one output register.
// Latency: 1 cycle from a valid input to a valid result; one state per cycle, no bubbles.
// Backpressure: none; when idle the result is held and out_valid is low.
module mix_columns #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mix_columns_if.slave bus
);
  import aes_pkg::*;

  state_t       stateIn;
  column_t      colOut [4];
  logic [0:127] nextMatrix;

  assign stateIn = bus.ShiftRows_Matrix;

  for (genvar c = 0; c < 4; c++) begin : gCol
    mix_single_column #(
      .INVERSE (INVERSE)
    ) uCol (
      .colIn  (stateIn[4*c +: 4]),
      .colOut (colOut[c])
    );
  end

  // Reassemble the four mixed columns into the column-major output state.
  always_comb begin
    nextMatrix = '0;
    for (int c = 0; c < 4; c++) begin
      nextMatrix[32*c +: 32] = colOut[c];
    end
  end

  // Capture the result on valid input and hold it otherwise. Reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.MixColumns_Matrix <= '0;
      bus.out_valid         <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.MixColumns_Matrix <= nextMatrix;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Directed bench for mix_columns: forward and inverse instances checked against known AES vectors.
// Latency: results are sampled 1 ns after the capture edge.
// Backpressure: none; inputs are driven every cycle from tasks.
module tb_mix_columns;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mix_columns_if fwdBus ();
  mix_columns_if invBus ();

  mix_columns #(.INVERSE(1'b0)) uFwd (.clk(clk), .rst(rst), .bus(fwdBus.slave));
  mix_columns #(.INVERSE(1'b1)) uInv (.clk(clk), .rst(rst), .bus(invBus.slave));

  localparam logic [0:127] R1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] R1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] R2_IN  = 128'h49db873b453953897f02d2f177de961a;
  localparam logic [0:127] R2_OUT = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
  localparam logic [0:127] R3_IN  = 128'hacc1d6b8efb55a7b1323cfdf457311b5;
  localparam logic [0:127] R3_OUT = 128'h75ec0993200b633353c0cf7cbb25d0dc;
  localparam logic [0:127] COL_IN  = 128'h01010101db13534501010101db135345;
  localparam logic [0:127] COL_OUT = 128'h010101018e4da1bc010101018e4da1bc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fwdBus.in_valid = 1'b1;
    fwdBus.ShiftRows_Matrix = R1_IN;
    invBus.in_valid = 1'b1;
    invBus.ShiftRows_Matrix = R1_OUT;
    step();
    checks++;
    if (fwdBus.MixColumns_Matrix !== 128'h0) begin
      errors++;
      $display("FAIL reset_fwd_data got %h want 0", fwdBus.MixColumns_Matrix);
    end
    checks++;
    if (fwdBus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwd_valid got %b want 0", fwdBus.out_valid);
    end
    checks++;
    if (invBus.MixColumns_Matrix !== 128'h0) begin
      errors++;
      $display("FAIL reset_inv_data got %h want 0", invBus.MixColumns_Matrix);
    end
    checks++;
    if (invBus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_inv_valid got %b want 0", invBus.out_valid);
    end
    rst = 1'b0;
    fwdBus.in_valid = 1'b0;
    invBus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_forward();
    logic [0:127] ins  [3];
    logic [0:127] outs [3];
    ins  = '{R1_IN, R2_IN, R3_IN};
    outs = '{R1_OUT, R2_OUT, R3_OUT};
    for (int i = 0; i < 3; i++) begin
      fwdBus.ShiftRows_Matrix = ins[i];
      fwdBus.in_valid = 1'b1;
      step();
      fwdBus.in_valid = 1'b0;
      checks++;
      if (fwdBus.MixColumns_Matrix !== outs[i]) begin
        errors++;
        $display("FAIL fwd_round%0d got %h want %h", i + 1, fwdBus.MixColumns_Matrix, outs[i]);
      end
      checks++;
      if (fwdBus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fwd_round%0d_valid got %b want 1", i + 1, fwdBus.out_valid);
      end
      step();
    end
  endtask

  task automatic test_inverse();
    logic [0:127] ins  [3];
    logic [0:127] outs [3];
    ins  = '{R1_OUT, R2_OUT, COL_OUT};
    outs = '{R1_IN, R2_IN, COL_IN};
    for (int i = 0; i < 3; i++) begin
      invBus.ShiftRows_Matrix = ins[i];
      invBus.in_valid = 1'b1;
      step();
      invBus.in_valid = 1'b0;
      checks++;
      if (invBus.MixColumns_Matrix !== outs[i]) begin
        errors++;
        $display("FAIL inv_vec%0d got %h want %h", i, invBus.MixColumns_Matrix, outs[i]);
      end
      checks++;
      if (invBus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL inv_vec%0d_valid got %b want 1", i, invBus.out_valid);
      end
    end
    step();
  endtask

  task automatic test_roundtrip();
    logic [0:127] orig;
    for (int i = 0; i < 4; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      fwdBus.ShiftRows_Matrix = orig;
      fwdBus.in_valid = 1'b1;
      step();
      fwdBus.in_valid = 1'b0;
      invBus.ShiftRows_Matrix = fwdBus.MixColumns_Matrix;
      invBus.in_valid = 1'b1;
      step();
      invBus.in_valid = 1'b0;
      checks++;
      if (invBus.MixColumns_Matrix !== orig) begin
        errors++;
        $display("FAIL roundtrip%0d got %h want %h", i, invBus.MixColumns_Matrix, orig);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [0:127] ins  [3];
    logic [0:127] outs [3];
    ins  = '{R1_IN, R2_IN, R3_IN};
    outs = '{R1_OUT, R2_OUT, R3_OUT};
    fwdBus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fwdBus.ShiftRows_Matrix = ins[i];
      step();
      checks++;
      if (fwdBus.MixColumns_Matrix !== outs[i] || fwdBus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream%0d got %h/%b want %h/1", i, fwdBus.MixColumns_Matrix,
                 fwdBus.out_valid, outs[i]);
      end
    end
    fwdBus.in_valid = 1'b0;
    fwdBus.ShiftRows_Matrix = R1_IN;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (fwdBus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d_valid got %b want 0", i, fwdBus.out_valid);
      end
      checks++;
      if (fwdBus.MixColumns_Matrix !== R3_OUT) begin
        errors++;
        $display("FAIL hold%0d_data got %h want %h", i, fwdBus.MixColumns_Matrix, R3_OUT);
      end
    end
  endtask

  task automatic test_reset_midstream();
    fwdBus.in_valid = 1'b1;
    fwdBus.ShiftRows_Matrix = R1_IN;
    step();
    rst = 1'b1;
    fwdBus.ShiftRows_Matrix = R2_IN;
    step();
    checks++;
    if (fwdBus.MixColumns_Matrix !== 128'h0 || fwdBus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %h/%b want 0/0", fwdBus.MixColumns_Matrix, fwdBus.out_valid);
    end
    rst = 1'b0;
    fwdBus.ShiftRows_Matrix = R3_IN;
    step();
    fwdBus.in_valid = 1'b0;
    checks++;
    if (fwdBus.MixColumns_Matrix !== R3_OUT || fwdBus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got %h/%b want %h/1", fwdBus.MixColumns_Matrix,
               fwdBus.out_valid, R3_OUT);
    end
    step();
  endtask

  task automatic test_columns();
    fwdBus.ShiftRows_Matrix = COL_IN;
    fwdBus.in_valid = 1'b1;
    step();
    fwdBus.in_valid = 1'b0;
    checks++;
    if (fwdBus.MixColumns_Matrix !== COL_OUT) begin
      errors++;
      $display("FAIL column_edge got %h want %h", fwdBus.MixColumns_Matrix, COL_OUT);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    fwdBus.in_valid = 1'b0;
    fwdBus.ShiftRows_Matrix = '0;
    invBus.in_valid = 1'b0;
    invBus.ShiftRows_Matrix = '0;
    test_reset();
    test_forward();
    test_inverse();
    test_roundtrip();
    test_back_to_back();
    test_reset_midstream();
    test_columns();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
